// File: rtl/fetch_ctrl_if.sv
// Fetch-path bus bundle: redirect inputs, instruction-memory req/ack channel
// and the instruction stream toward decode.
//   master : fetch_ctrl side (drives imem_req/addr and the decode stream)
//   slave  : environment side (memory, branch unit, decode)
interface fetch_ctrl_if #(
  parameter int unsigned WORD      = 64,
  parameter int unsigned INSTR_LEN = 32
);
  logic [WORD-1:0]      branch_target;
  logic                 pc_src;
  logic                 imem_req;
  logic [WORD-1:0]      imem_addr;
  logic                 imem_ack;
  logic [INSTR_LEN-1:0] imem_rdata;
  logic                 instr_valid;
  logic [INSTR_LEN-1:0] instruction;
  logic [WORD-1:0]      instr_pc;
  logic                 instr_ready;

  modport master (
    input  branch_target, pc_src, imem_ack, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instruction, instr_pc
  );

  modport slave (
    output branch_target, pc_src, imem_ack, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Owns the PC, issues one request at a time to
// a multi-cycle instruction memory and buffers returned instructions in a
// small FIFO toward decode. Branch redirects flush the FIFO and squash any
// in-flight fetch.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : fetch_ctrl_if.master (redirect, imem req/ack, decode stream)
module fetch_ctrl #(
  parameter int unsigned    WORD      = 64,
  parameter int unsigned    INSTR_LEN = 32,
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int unsigned    BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  fetch_ctrl_if.master    bus
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [WORD-1:0]      r_pc, w_pc_nxt;
  logic [WORD-1:0]      r_addr, w_addr_nxt;
  logic                 r_squash, w_squash_nxt;

  logic [INSTR_LEN-1:0] r_mem_instr [BUF_DEPTH];
  logic [WORD-1:0]      r_mem_pc    [BUF_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count, w_count_nxt;

  logic w_ack, w_push, w_pop, w_valid, w_space;

  assign w_valid = (r_count != '0);
  assign w_ack   = (r_state == S_REQ) & bus.imem_ack;
  // Acks for a squashed fetch, or coinciding with a redirect, are dropped.
  assign w_push  = w_ack & ~r_squash & ~bus.pc_src;
  // A redirect flushes the FIFO, so a simultaneous pop is meaningless.
  assign w_pop   = w_valid & bus.instr_ready & ~bus.pc_src;

  always_comb begin
    w_count_nxt = r_count;
    if (bus.pc_src) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Credit check is made against the post-edge occupancy; a new request is
  // only ever launched when none is outstanding, so outstanding counts as 0.
  assign w_space = (w_count_nxt < CNT_W'(BUF_DEPTH));

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_addr_nxt   = r_addr;
    w_squash_nxt = r_squash;

    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        w_addr_nxt  = r_pc;
      end
      S_REQ: begin
        if (bus.imem_ack) begin
          if (!r_squash) begin
            w_pc_nxt = r_pc + WORD'(4);
          end
          w_squash_nxt = 1'b0;
          if (w_space) begin
            w_addr_nxt = w_pc_nxt;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_space) begin
          w_state_nxt = S_REQ;
          w_addr_nxt  = r_pc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Redirect overrides the normal sequencing. With a fetch still in
    // flight the old address is held until its ack, which is then discarded.
    if (bus.pc_src) begin
      w_pc_nxt = bus.branch_target;
      if ((r_state == S_REQ) && !bus.imem_ack) begin
        w_state_nxt  = S_REQ;
        w_addr_nxt   = r_addr;
        w_squash_nxt = 1'b1;
      end else begin
        w_state_nxt  = S_REQ;
        w_addr_nxt   = bus.branch_target;
        w_squash_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_addr   <= RESET_PC;
      r_squash <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_addr   <= w_addr_nxt;
      r_squash <= w_squash_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      if (bus.pc_src) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
          r_mem_pc[r_wr_ptr]    <= r_pc;
          r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  assign bus.imem_req    = (r_state == S_REQ);
  assign bus.imem_addr   = r_addr;
  assign bus.instr_valid = w_valid;
  assign bus.instruction = w_valid ? r_mem_instr[r_rd_ptr] : '0;
  assign bus.instr_pc    = w_valid ? r_mem_pc[r_rd_ptr]    : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_fail;

  fetch_ctrl_if #(.WORD(64), .INSTR_LEN(32)) bus ();

  fetch_ctrl #(
    .WORD(64),
    .INSTR_LEN(32),
    .RESET_PC(64'h0),
    .BUF_DEPTH(2)
  ) u_dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [63:0] addr,
                         input logic valid, input logic [63:0] pc, input logic [31:0] instr);
    chk_eq({tag, ".req"},   64'(bus.imem_req),    64'(req));
    chk_eq({tag, ".addr"},  bus.imem_addr,        addr);
    chk_eq({tag, ".valid"}, 64'(bus.instr_valid), 64'(valid));
    chk_eq({tag, ".pc"},    bus.instr_pc,         pc);
    chk_eq({tag, ".instr"}, 64'(bus.instruction), 64'(instr));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic src,
                       input logic [63:0] tgt, input logic rdy);
    bus.imem_ack      = ack;
    bus.imem_rdata    = rdata;
    bus.pc_src        = src;
    bus.branch_target = tgt;
    bus.instr_ready   = rdy;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);

    // 1: streaming fetch, ack one cycle after each request, decode always ready
    do_reset;
    chk_bus("t1.rst", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t1.r0", 1'b1, 64'h0, 1'b0, 64'h0, 32'h0);
    drive(1'b1, 32'hA0, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t1.a0", 1'b1, 64'h4, 1'b1, 64'h0, 32'hA0);
    drive(1'b1, 32'hA4, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t1.a4", 1'b1, 64'h8, 1'b1, 64'h4, 32'hA4);
    drive(1'b1, 32'hA8, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t1.a8", 1'b1, 64'hC, 1'b1, 64'h8, 32'hA8);
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t1.drain", 1'b1, 64'hC, 1'b0, 64'h0, 32'h0);

    // 2: decode stalled, FIFO fills to depth 2 and requests stop
    do_reset;
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick; chk_bus("t2.r0", 1'b1, 64'h0, 1'b0, 64'h0, 32'h0);
    drive(1'b1, 32'h11, 1'b0, 64'h0, 1'b0);
    tick; chk_bus("t2.a0", 1'b1, 64'h4, 1'b1, 64'h0, 32'h11);
    drive(1'b1, 32'h22, 1'b0, 64'h0, 1'b0);
    tick; chk_bus("t2.full", 1'b0, 64'h4, 1'b1, 64'h0, 32'h11);
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick; chk_bus("t2.hold", 1'b0, 64'h4, 1'b1, 64'h0, 32'h11);
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t2.pop", 1'b1, 64'h8, 1'b1, 64'h4, 32'h22);

    // 3: redirect while a 3-cycle fetch to 0x8 is in flight
    do_reset;
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t3.r0", 1'b1, 64'h0, 1'b0, 64'h0, 32'h0);
    drive(1'b1, 32'h1, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t3.a0", 1'b1, 64'h4, 1'b1, 64'h0, 32'h1);
    drive(1'b1, 32'h2, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t3.a4", 1'b1, 64'h8, 1'b1, 64'h4, 32'h2);
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t3.wait", 1'b1, 64'h8, 1'b0, 64'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 64'h100, 1'b1);
    tick; chk_bus("t3.redir", 1'b1, 64'h8, 1'b0, 64'h0, 32'h0);
    drive(1'b1, 32'hDEAD, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t3.squash", 1'b1, 64'h100, 1'b0, 64'h0, 32'h0);
    drive(1'b1, 32'h33, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t3.tgt", 1'b1, 64'h104, 1'b1, 64'h100, 32'h33);

    // 4: redirect coincident with ack and with a pop
    drive(1'b1, 32'h44, 1'b1, 64'h200, 1'b1);
    tick; chk_bus("t4.redir", 1'b1, 64'h200, 1'b0, 64'h0, 32'h0);
    drive(1'b1, 32'h55, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t4.tgt", 1'b1, 64'h204, 1'b1, 64'h200, 32'h55);

    // 5: back-to-back redirects during squash, last one near top of space, PC wraps
    drive(1'b0, 32'h0, 1'b1, 64'h300, 1'b1);
    tick; chk_bus("t5.redir1", 1'b1, 64'h204, 1'b0, 64'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    tick; chk_bus("t5.redir2", 1'b1, 64'h204, 1'b0, 64'h0, 32'h0);
    drive(1'b1, 32'hBAD, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t5.squash", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 32'h0);
    drive(1'b1, 32'h66, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t5.top", 1'b1, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h66);
    drive(1'b1, 32'h77, 1'b0, 64'h0, 1'b1);
    tick; chk_bus("t5.wrap", 1'b1, 64'h4, 1'b1, 64'h0, 32'h77);

    // 6: reset with a buffered entry and a request outstanding; stale ack ignored
    do_reset;
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick; chk_bus("t6.r0", 1'b1, 64'h0, 1'b0, 64'h0, 32'h0);
    drive(1'b1, 32'h11, 1'b0, 64'h0, 1'b0);
    tick; chk_bus("t6.busy", 1'b1, 64'h4, 1'b1, 64'h0, 32'h11);
    rst_n = 1'b0;
    #1;
    chk_bus("t6.async", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    tick;
    rst_n = 1'b1;
    tick; chk_bus("t6.rel", 1'b1, 64'h0, 1'b0, 64'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick; chk_bus("t6.stale", 1'b1, 64'h0, 1'b0, 64'h0, 32'h0);
    drive(1'b1, 32'h88, 1'b0, 64'h0, 1'b0);
    tick; chk_bus("t6.first", 1'b1, 64'h4, 1'b1, 64'h0, 32'h88);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
